// File: rtl/rf_rename_multiport_pkg.sv
// Shared sizing constants and types for the architectural register file
// and its rename-tag table.
package rf_rename_multiport_pkg;

    localparam int XLEN           = 32;
    localparam int REG_NUM        = 32;
    localparam int REG_W          = 5;
    localparam int REG_NUM_WIDTH  = REG_W;
    localparam int TAG_W          = 5;
    localparam int ROB_SIZE_WIDTH = TAG_W;
    localparam int NUM_RD         = 2;
    localparam int NUM_CMT        = 2;

    typedef logic [XLEN-1:0]  xlen_t;
    typedef logic [REG_W-1:0] reg_t;
    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/rf_rename_multiport_if.sv
// Commit, rename and operand-read bundle between decode/issue, ROB commit
// and the register file.
interface rf_rename_multiport_if
    import rf_rename_multiport_pkg::*;
();

    logic [NUM_CMT-1:0]       cmt_valid;
    logic [NUM_CMT*REG_W-1:0] cmt_rd;
    logic [NUM_CMT*XLEN-1:0]  cmt_value;
    logic [NUM_CMT*TAG_W-1:0] cmt_tag;
    logic                     dec_valid;
    reg_t                     dec_rd;
    tag_t                     dec_tag;
    logic [NUM_RD*REG_W-1:0]  rd_addr;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_RD*TAG_W-1:0]  rd_tag;
    logic [NUM_RD*XLEN-1:0]   rd_value;

    modport master (
        output cmt_valid, cmt_rd, cmt_value, cmt_tag,
        output dec_valid, dec_rd, dec_tag, rd_addr,
        input  rd_busy, rd_tag, rd_value
    );

    modport slave (
        input  cmt_valid, cmt_rd, cmt_value, cmt_tag,
        input  dec_valid, dec_rd, dec_tag, rd_addr,
        output rd_busy, rd_tag, rd_value
    );

endinterface

// File: rtl/rf_rename_multiport_read_port.sv
// One operand read port: stored entry, overridden by a same-cycle commit
// that retires the pending producer, with x0 forced to zero.
module rf_read_port
    import rf_rename_multiport_pkg::*;
(
    input  reg_t                     addr,
    input  logic                     st_busy,
    input  tag_t                     st_tag,
    input  xlen_t                    st_value,
    input  logic [NUM_CMT-1:0]       cmt_valid,
    input  logic [NUM_CMT*REG_W-1:0] cmt_rd,
    input  logic [NUM_CMT*XLEN-1:0]  cmt_value,
    input  logic [NUM_CMT*TAG_W-1:0] cmt_tag,
    output logic                     busy,
    output tag_t                     tag,
    output xlen_t                    value
);

    always_comb begin
        busy  = st_busy;
        tag   = st_tag;
        value = st_value;
        if (addr == '0) begin
            busy  = 1'b0;
            value = '0;
        end else if (st_busy) begin
            // Ascending scan so the youngest matching commit wins.
            for (int k = 0; k < NUM_CMT; k++) begin
                if (cmt_valid[k] &&
                    cmt_rd[k*REG_W +: REG_W] == addr &&
                    cmt_tag[k*TAG_W +: TAG_W] == st_tag) begin
                    busy  = 1'b0;
                    value = cmt_value[k*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/rf_rename_multiport.sv
// Architectural register file with per-register rename tags, multiple
// commit ports, commit bypass on reads and mispredict flush.
module rf_rename_multiport
    import rf_rename_multiport_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  is_flush_in,
    rf_rename_multiport_if.slave  rf_if
);

    xlen_t              regs [REG_NUM];
    tag_t               tags [REG_NUM];
    logic [REG_NUM-1:0] busy;

    reg_t  c_rd  [NUM_CMT];
    xlen_t c_val [NUM_CMT];
    tag_t  c_tag [NUM_CMT];

    for (genvar k = 0; k < NUM_CMT; k++) begin : g_cmt
        assign c_rd[k]  = rf_if.cmt_rd[k*REG_W +: REG_W];
        assign c_val[k] = rf_if.cmt_value[k*XLEN +: XLEN];
        assign c_tag[k] = rf_if.cmt_tag[k*TAG_W +: TAG_W];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            // Later ports overwrite earlier ones through NBA ordering.
            for (int k = 0; k < NUM_CMT; k++) begin
                if (rf_if.cmt_valid[k] && c_rd[k] != '0) begin
                    regs[c_rd[k]] <= c_val[k];
                    if (busy[c_rd[k]] && tags[c_rd[k]] == c_tag[k])
                        busy[c_rd[k]] <= 1'b0;
                end
            end
            if (is_flush_in) begin
                busy <= '0;
            end else if (rf_if.dec_valid && rf_if.dec_rd != '0) begin
                busy[rf_if.dec_rd] <= 1'b1;
                tags[rf_if.dec_rd] <= rf_if.dec_tag;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_t ra;
        assign ra = rf_if.rd_addr[p*REG_W +: REG_W];

        rf_read_port u_rp (
            .addr      (ra),
            .st_busy   (busy[ra]),
            .st_tag    (tags[ra]),
            .st_value  (regs[ra]),
            .cmt_valid (rf_if.cmt_valid),
            .cmt_rd    (rf_if.cmt_rd),
            .cmt_value (rf_if.cmt_value),
            .cmt_tag   (rf_if.cmt_tag),
            .busy      (rf_if.rd_busy[p]),
            .tag       (rf_if.rd_tag[p*TAG_W +: TAG_W]),
            .value     (rf_if.rd_value[p*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_rf_rename_multiport.sv
// Self-checking bench: directed scenarios plus randomized traffic
// compared against a behavioural register/scoreboard model.
module tb_rf_rename_multiport;
    import rf_rename_multiport_pkg::*;

    logic clk_in = 1'b0;
    logic rst_n_in;
    logic rdy_in;
    logic is_flush_in;

    rf_rename_multiport_if rf_if ();

    rf_rename_multiport dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .is_flush_in (is_flush_in),
        .rf_if       (rf_if)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [4:0]  m_tag  [32];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 0;
            m_busy[i] = 0;
            m_tag[i]  = 0;
        end
    endtask

    function automatic logic [4:0] c_rd(int k);
        logic [NUM_CMT*REG_W-1:0] v;
        v = rf_if.cmt_rd;
        return v[k*5 +: 5];
    endfunction

    function automatic logic [4:0] c_tg(int k);
        logic [NUM_CMT*TAG_W-1:0] v;
        v = rf_if.cmt_tag;
        return v[k*5 +: 5];
    endfunction

    function automatic logic [31:0] c_vl(int k);
        logic [NUM_CMT*XLEN-1:0] v;
        v = rf_if.cmt_value;
        return v[k*32 +: 32];
    endfunction

    // Expected operand view for register a given pre-edge model state.
    task automatic model_read(input logic [4:0] a, output bit b,
                              output logic [4:0] t, output logic [31:0] v);
        b = m_busy[a];
        t = m_tag[a];
        v = m_val[a];
        if (a == 0) begin
            b = 0;
            v = 0;
        end else if (m_busy[a]) begin
            for (int k = NUM_CMT - 1; k >= 0; k--) begin
                if (rf_if.cmt_valid[k] && c_rd(k) == a && c_tg(k) == m_tag[a]) begin
                    b = 0;
                    v = c_vl(k);
                    break;
                end
            end
        end
    endtask

    task automatic model_clock();
        bit          nb [32];
        logic [31:0] nv [32];
        logic [4:0]  nt [32];
        if (!rdy_in) return;
        nb = m_busy;
        nv = m_val;
        nt = m_tag;
        for (int k = 0; k < NUM_CMT; k++) begin
            if (rf_if.cmt_valid[k] && c_rd(k) != 0) begin
                nv[c_rd(k)] = c_vl(k);
                if (m_busy[c_rd(k)] && m_tag[c_rd(k)] == c_tg(k))
                    nb[c_rd(k)] = 0;
            end
        end
        if (is_flush_in) begin
            for (int i = 0; i < 32; i++) nb[i] = 0;
        end else if (rf_if.dec_valid && rf_if.dec_rd != 0) begin
            nb[rf_if.dec_rd] = 1;
            nt[rf_if.dec_rd] = rf_if.dec_tag;
        end
        m_busy = nb;
        m_val  = nv;
        m_tag  = nt;
    endtask

    task automatic check_reads(input string tag);
        bit          b;
        logic [4:0]  t;
        logic [31:0] v;
        logic [NUM_RD*REG_W-1:0] ra;
        logic [NUM_RD*TAG_W-1:0] rt;
        logic [NUM_RD*XLEN-1:0]  rv;
        ra = rf_if.rd_addr;
        rt = rf_if.rd_tag;
        rv = rf_if.rd_value;
        for (int p = 0; p < NUM_RD; p++) begin
            model_read(ra[p*5 +: 5], b, t, v);
            chk({tag, "_busy"}, 64'(rf_if.rd_busy[p]), 64'(b));
            if (b) chk({tag, "_tag"}, 64'(rt[p*5 +: 5]), 64'(t));
            else   chk({tag, "_val"}, 64'(rv[p*32 +: 32]), 64'(v));
        end
    endtask

    task automatic idle();
        rdy_in          = 1'b1;
        is_flush_in     = 1'b0;
        rf_if.cmt_valid = '0;
        rf_if.cmt_rd    = '0;
        rf_if.cmt_value = '0;
        rf_if.cmt_tag   = '0;
        rf_if.dec_valid = 1'b0;
        rf_if.dec_rd    = '0;
        rf_if.dec_tag   = '0;
    endtask

    task automatic set_cmt(input int k, input logic [4:0] rd,
                           input logic [4:0] tg, input logic [31:0] v);
        rf_if.cmt_valid[k]          = 1'b1;
        rf_if.cmt_rd[k*5 +: 5]      = rd;
        rf_if.cmt_tag[k*5 +: 5]     = tg;
        rf_if.cmt_value[k*32 +: 32] = v;
    endtask

    task automatic set_dec(input logic [4:0] rd, input logic [4:0] tg);
        rf_if.dec_valid = 1'b1;
        rf_if.dec_rd    = rd;
        rf_if.dec_tag   = tg;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rf_if.rd_addr = {a1, a0};
    endtask

    task automatic settle(input string tag);
        #1;
        check_reads(tag);
    endtask

    task automatic clk_step();
        @(posedge clk_in);
        model_clock();
        @(negedge clk_in);
        idle();
    endtask

    initial begin
        idle();
        set_rd(5'd5, 5'd0);
        model_reset();
        rst_n_in = 1'b0;
        #2;
        chk("rst_busy", 64'(rf_if.rd_busy[0]), 64'd0);
        chk("rst_val", 64'(rf_if.rd_value[31:0]), 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        set_dec(5'd3, 5'd7);
        settle("t2a");
        clk_step();
        set_cmt(0, 5'd3, 5'd7, 32'hDEAD);
        set_rd(5'd3, 5'd3);
        settle("t2b");
        chk("t2_byp_busy", 64'(rf_if.rd_busy[0]), 64'd0);
        chk("t2_byp_val", 64'(rf_if.rd_value[31:0]), 64'hDEAD);
        clk_step();
        settle("t2c");
        chk("t2_st_busy", 64'(rf_if.rd_busy[0]), 64'd0);
        chk("t2_st_val", 64'(rf_if.rd_value[31:0]), 64'hDEAD);

        set_dec(5'd3, 5'd7);
        clk_step();
        set_dec(5'd3, 5'd9);
        clk_step();
        set_cmt(0, 5'd3, 5'd7, 32'd1);
        settle("t3a");
        clk_step();
        settle("t3b");
        chk("t3_busy", 64'(rf_if.rd_busy[0]), 64'd1);
        chk("t3_tag", 64'(rf_if.rd_tag[4:0]), 64'd9);

        set_dec(5'd4, 5'd5);
        clk_step();
        set_cmt(0, 5'd4, 5'd2, 32'hAAAA);
        set_cmt(1, 5'd4, 5'd5, 32'hBBBB);
        set_rd(5'd4, 5'd3);
        settle("t4a");
        chk("t4_byp_val", 64'(rf_if.rd_value[31:0]), 64'hBBBB);
        clk_step();
        settle("t4b");
        chk("t4_busy", 64'(rf_if.rd_busy[0]), 64'd0);
        chk("t4_val", 64'(rf_if.rd_value[31:0]), 64'hBBBB);

        set_dec(5'd9, 5'd3);
        clk_step();
        is_flush_in = 1'b1;
        set_cmt(0, 5'd6, 5'd1, 32'h55);
        set_dec(5'd8, 5'd4);
        clk_step();
        set_rd(5'd6, 5'd8);
        settle("t5a");
        chk("t5_x6", 64'(rf_if.rd_value[31:0]), 64'h55);
        chk("t5_x8_busy", 64'(rf_if.rd_busy[1]), 64'd0);
        set_rd(5'd9, 5'd3);
        settle("t5b");
        chk("t5_x9_busy", 64'(rf_if.rd_busy[0]), 64'd0);
        chk("t5_x3_busy", 64'(rf_if.rd_busy[1]), 64'd0);

        rdy_in = 1'b0;
        set_cmt(0, 5'd6, 5'd0, 32'h77);
        set_dec(5'd6, 5'd1);
        clk_step();
        set_rd(5'd6, 5'd0);
        set_cmt(0, 5'd0, 5'd3, 32'hFF);
        set_dec(5'd0, 5'd3);
        settle("t6a");
        chk("t6_hold_busy", 64'(rf_if.rd_busy[0]), 64'd0);
        chk("t6_hold_val", 64'(rf_if.rd_value[31:0]), 64'h55);
        clk_step();
        settle("t6b");
        chk("t6_x0_busy", 64'(rf_if.rd_busy[1]), 64'd0);
        chk("t6_x0_val", 64'(rf_if.rd_value[63:32]), 64'd0);

        for (int n = 0; n < 400; n++) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            is_flush_in = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NUM_CMT; k++) begin
                logic [4:0] r;
                logic [4:0] t;
                r = 5'($urandom_range(0, 7));
                t = ($urandom_range(0, 3) != 0) ? m_tag[r] : 5'($urandom);
                if ($urandom_range(0, 1) == 1) set_cmt(k, r, t, $urandom);
            end
            if ($urandom_range(0, 1) == 1)
                set_dec(5'($urandom_range(0, 7)), 5'($urandom));
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            settle("rnd");
            clk_step();
        end

        set_dec(5'd5, 5'd2);
        clk_step();
        set_rd(5'd5, 5'd5);
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("arst_busy0", 64'(rf_if.rd_busy[0]), 64'd0);
        chk("arst_busy1", 64'(rf_if.rd_busy[1]), 64'd0);
        chk("arst_val", 64'(rf_if.rd_value[31:0]), 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        settle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
